// File: rtl/interrupt_sequencer_pkg.sv
// Shared definitions for the interrupt/reset microsequencer.
// Holds the default vector addresses and stack page, the cause encoding
// presented on the cause port, the sequencer state encoding, and the helper
// that builds the status byte written to the stack.
package interrupt_sequencer_pkg;

  localparam logic [15:0] NMI_VEC_DEF    = 16'hFFFA;
  localparam logic [15:0] RES_VEC_DEF    = 16'hFFFC;
  localparam logic [15:0] IRQ_VEC_DEF    = 16'hFFFE;
  localparam logic [7:0]  STACK_PAGE_DEF = 8'h01;
  localparam int          I_BIT_DEF      = 2;

  typedef enum logic [1:0] {
    CAUSE_RES = 2'd0,
    CAUSE_NMI = 2'd1,
    CAUSE_IRQ = 2'd2,
    CAUSE_BRK = 2'd3
  } cause_e;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PUSH_PCH = 3'd1,
    ST_PUSH_PCL = 3'd2,
    ST_PUSH_P   = 3'd3,
    ST_VEC_LO   = 3'd4,
    ST_VEC_HI   = 3'd5,
    ST_LOAD     = 3'd6
  } state_e;

  // flags = {N,V,D,I,Z,C}; the pushed byte always carries bit 5 set and
  // the B bit set only for a software break.
  function automatic logic [7:0] pushed_status(input logic [5:0] flags,
                                               input logic       brk);
    return {flags[5:4], 1'b1, brk, flags[3:0]};
  endfunction

endpackage

// File: rtl/interrupt_sequencer_nmi_edge_latch.sv
// NMI edge detector and pending flag.
// Ports:
//   clk  in  system clock
//   res  in  asynchronous reset, active-high
//   q    in  qualified cycle (clk_enable && rdy); nothing changes without it
//   nmi  in  raw NMI line
//   clr  in  clear request, honoured on a qualified edge
//   pend out NMI pending
module nmi_edge_latch (
  input  logic clk,
  input  logic res,
  input  logic q,
  input  logic nmi,
  input  logic clr,
  output logic pend
);

  logic nmi_q;
  logic pend_q;

  // A new rising edge wins over a same-edge clear so it is never lost.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      nmi_q  <= 1'b0;
      pend_q <= 1'b0;
    end else if (q) begin
      nmi_q <= nmi;
      if (nmi && !nmi_q) begin
        pend_q <= 1'b1;
      end else if (clr) begin
        pend_q <= 1'b0;
      end
    end
  end

  assign pend = pend_q;

endmodule

// File: rtl/interrupt_sequencer.sv
// Interrupt/reset microsequencer: owns the bus for RES, NMI, IRQ and BRK
// entry. Pushes PCH, PCL and P (dummy stack reads for RES), fetches the
// vector and loads PC. Decode fetches opcodes only while busy is low.
// Ports:
//   clk, res (async, active-high), clk_enable, rdy   clocking / stall
//   irq, nmi, brk_req, boundary                      entry requests
//   pc, sp, status, data_in                          CPU state and read data
//   busy, address, data_out, rw                      bus ownership and cycle
//   sp_dec, set_i, pc_load, pc_value                 one-q-cycle side effects
//   cause                                            entry cause while busy
module interrupt_sequencer
  import interrupt_sequencer_pkg::*;
#(
  parameter int                ADDR_W     = 16,
  parameter int                DATA_W     = 8,
  parameter logic [7:0]        STACK_PAGE = STACK_PAGE_DEF,
  parameter logic [ADDR_W-1:0] NMI_VEC    = NMI_VEC_DEF,
  parameter logic [ADDR_W-1:0] RES_VEC    = RES_VEC_DEF,
  parameter logic [ADDR_W-1:0] IRQ_VEC    = IRQ_VEC_DEF,
  parameter int                I_BIT      = I_BIT_DEF
) (
  input  logic              clk,
  input  logic              res,
  input  logic              clk_enable,
  input  logic              rdy,
  input  logic              irq,
  input  logic              nmi,
  input  logic              brk_req,
  input  logic              boundary,
  input  logic [ADDR_W-1:0] pc,
  input  logic [7:0]        sp,
  input  logic [6:0]        status,
  input  logic [DATA_W-1:0] data_in,
  output logic              busy,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] data_out,
  output logic              rw,
  output logic              sp_dec,
  output logic              set_i,
  output logic              pc_load,
  output logic [ADDR_W-1:0] pc_value,
  output logic [1:0]        cause
);

  state_e            state_q, state_d;
  cause_e            cause_q, cause_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] lo_q, lo_d;
  logic              q_en;
  logic              nmi_pend;
  logic              nmi_clr;
  logic [ADDR_W-1:0] stack_addr;
  logic              unused_b_flag;

  assign q_en          = clk_enable & rdy;
  assign stack_addr    = ADDR_W'({STACK_PAGE, sp});
  assign unused_b_flag = status[4];

  function automatic logic [ADDR_W-1:0] vec_for(input cause_e c);
    case (c)
      CAUSE_RES: return RES_VEC;
      CAUSE_NMI: return NMI_VEC;
      default:   return IRQ_VEC;
    endcase
  endfunction

  nmi_edge_latch u_nmi (
    .clk  (clk),
    .res  (res),
    .q    (q_en),
    .nmi  (nmi),
    .clr  (nmi_clr),
    .pend (nmi_pend)
  );

  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    pc_d    = pc_q;
    lo_d    = lo_q;
    nmi_clr = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (boundary && (nmi_pend || brk_req || (irq && !status[I_BIT]))) begin
          state_d = ST_PUSH_PCH;
          pc_d    = pc;
          if (nmi_pend)     cause_d = CAUSE_NMI;
          else if (brk_req) cause_d = CAUSE_BRK;
          else              cause_d = CAUSE_IRQ;
        end
      end
      ST_PUSH_PCH: state_d = ST_PUSH_PCL;
      ST_PUSH_PCL: state_d = ST_PUSH_P;
      ST_PUSH_P: begin
        state_d = ST_VEC_LO;
        // A pending NMI steals an IRQ/BRK entry before its vector fetch.
        if ((cause_q == CAUSE_IRQ || cause_q == CAUSE_BRK) && nmi_pend) begin
          cause_d = CAUSE_NMI;
        end
      end
      ST_VEC_LO: begin
        state_d = ST_VEC_HI;
        nmi_clr = (cause_q == CAUSE_NMI);
      end
      ST_VEC_HI: begin
        state_d = ST_LOAD;
        lo_d    = data_in;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy     = (state_q != ST_IDLE);
    address  = '0;
    data_out = '0;
    rw       = 1'b1;
    sp_dec   = 1'b0;
    set_i    = 1'b0;
    pc_load  = 1'b0;
    pc_value = '0;
    cause    = cause_q;
    case (state_q)
      ST_PUSH_PCH, ST_PUSH_PCL, ST_PUSH_P: begin
        address = stack_addr;
        sp_dec  = 1'b1;
        if (cause_q != CAUSE_RES) begin
          rw = 1'b0;
          if (state_q == ST_PUSH_PCH)      data_out = pc_q[ADDR_W-1 -: DATA_W];
          else if (state_q == ST_PUSH_PCL) data_out = pc_q[DATA_W-1:0];
          else data_out = DATA_W'(pushed_status({status[6:5], status[3:0]},
                                                cause_q == CAUSE_BRK));
        end
      end
      ST_VEC_LO: begin
        address = vec_for(cause_q);
        set_i   = 1'b1;
      end
      ST_VEC_HI: address = vec_for(cause_q) + ADDR_W'(1);
      ST_LOAD: begin
        pc_value = ADDR_W'({data_in, lo_q});
        pc_load  = 1'b1;
      end
      default: ;
    endcase
    // Reset forces the bus quiet immediately, independent of the clock.
    if (res) begin
      busy     = 1'b1;
      address  = '0;
      data_out = '0;
      rw       = 1'b1;
      sp_dec   = 1'b0;
      set_i    = 1'b0;
      pc_load  = 1'b0;
      pc_value = '0;
    end
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state_q <= ST_PUSH_PCH;
      cause_q <= CAUSE_RES;
    end else if (q_en) begin
      state_q <= state_d;
      cause_q <= cause_d;
    end
  end

  always_ff @(posedge clk) begin
    if (q_en) begin
      pc_q <= pc_d;
      lo_q <= lo_d;
    end
  end

endmodule
